mux_2x1_reg: RTL and testbench

MUX_2X1_REG -- requirements
Module: mux_2x1_reg

---
 rtl/mux_2x1_reg.sv | 73 +++++++
 tb/tb_mux_2x1_reg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_reg.sv
// -----------------------------------------------------------------------------
// mux_2x1_reg
//
// Two-input multiplexer with both a combinational and a registered result.
// The registered path captures the combinational result on every rising clock
// edge while out of reset, giving exactly one cycle of latency.
//
// Parameters
//   WIDTH        data width of A_in, B_in, Y_comb_out and Y_out (legal 1..64)
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        asynchronous, active-low reset
//   A_in         data input chosen when Select_in = 0
//   B_in         data input chosen when Select_in = 1
//   Select_in    select line
//   Y_comb_out   combinational mux result, zero latency, unaffected by reset
//   Y_out        registered mux result, cleared to zero by reset
//   valid_out    registered-output qualifier (see below)
//   Y_parity_out even parity (XOR reduction) of Y_out; present only when the
//                macro MUX_2X1_REG_PARITY_EN is defined
//
// Output qualifier: valid_out is low while reset is asserted and rises at the
// first rising edge with reset high, i.e. together with the first capture into
// Y_out. From then on every Y_out value is a real sample of Y_comb_out, and
// valid_out stays high until reset is asserted again. There is no
// back-pressure: the register captures unconditionally on every edge.
//
// Optional feature macro: MUX_2X1_REG_PARITY_EN
// -----------------------------------------------------------------------------
module mux_2x1_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             Select_in,
   output logic [WIDTH-1:0] Y_comb_out,
   output logic [WIDTH-1:0] Y_out,
`ifdef MUX_2X1_REG_PARITY_EN
   output logic             valid_out,
   output logic             Y_parity_out
`else
   output logic             valid_out
`endif
);

   // A continuous conditional operator is used on purpose: when Select_in is
   // X/Z in simulation it merges A_in and B_in bitwise, yielding the common
   // value where they agree and X where they differ. An if/else form would
   // silently pick one input instead.
   assign Y_comb_out = Select_in ? B_in : A_in;

   // Registered path. Non-blocking updates sample the pre-edge inputs, so
   // inputs changing in the same timestep as the edge do not race the capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Y_out     <= '0;
         valid_out <= 1'b0;
      end else begin
         Y_out     <= Y_comb_out;
         valid_out <= 1'b1;
      end
   end

`ifdef MUX_2X1_REG_PARITY_EN
   // Derived straight from the register, so it changes on the same cycle as
   // Y_out and reads 0 during reset (XOR of all zeros).
   assign Y_parity_out = ^Y_out;
`endif

endmodule

// File: tb/tb_mux_2x1_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_2x1_reg
//
// Directed testbench for mux_2x1_reg at WIDTH = 8. Inputs are driven on the
// falling clock edge; registered outputs are sampled 1 ns after the rising
// edge and combinational outputs 1 ns after the input change. Expected values
// are hand-computed constants held in the bench.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_2x1_reg;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic [W-1:0] A_in;
   logic [W-1:0] B_in;
   logic         Select_in;
   logic [W-1:0] Y_comb_out;
   logic [W-1:0] Y_out;
   logic         valid_out;
`ifdef MUX_2X1_REG_PARITY_EN
   logic         Y_parity_out;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------------------------------------------------------- clock/reset
   initial clk = 1'b0;
   always #10 clk = ~clk;

   mux_2x1_reg #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .A_in       (A_in),
      .B_in       (B_in),
      .Select_in  (Select_in),
      .Y_comb_out (Y_comb_out),
      .Y_out      (Y_out),
`ifdef MUX_2X1_REG_PARITY_EN
      .valid_out  (valid_out),
      .Y_parity_out (Y_parity_out)
`else
      .valid_out  (valid_out)
`endif
   );

   // Watchdog: the sequence is clock-driven only, but never allow a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      reset     = 1'b0;
      A_in      = '0;
      B_in      = '0;
      Select_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (Y_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_y_out: got %h, required 00", Y_out);
      end
      tests_run++;
      if (valid_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid: got %b, required 0", valid_out);
      end
      tests_run++;
      if (Y_comb_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_comb: got %h, required 00", Y_comb_out);
      end
`ifdef MUX_2X1_REG_PARITY_EN
      tests_run++;
      if (Y_parity_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_parity: got %b, required 0", Y_parity_out);
      end
`endif
   endtask

   task automatic test_release();
      @(negedge clk);
      B_in = 8'h01;
      #1;
      tests_run++;
      if (Y_comb_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL release_comb_sel0: got %h, required 00", Y_comb_out);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (Y_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL release_first_capture: got %h, required 00", Y_out);
      end
      tests_run++;
      if (valid_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL release_valid: got %b, required 1", valid_out);
      end
   endtask

   task automatic test_select();
      @(negedge clk);
      Select_in = 1'b1;
      #1;
      tests_run++;
      if (Y_comb_out !== 8'h01) begin
         tests_failed++;
         $display("FAIL select_comb: got %h, required 01", Y_comb_out);
      end
      tests_run++;
      if (Y_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL select_y_before_edge: got %h, required 00", Y_out);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (Y_out !== 8'h01) begin
         tests_failed++;
         $display("FAIL select_y_after_edge: got %h, required 01", Y_out);
      end
   endtask

   // A_in = 0, B_in = 1, Select_in starts at 1 with Y_out = 1.
   task automatic test_toggle();
      logic [W-1:0] exp_comb [5] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00};
      logic [W-1:0] exp_prev = 8'h01;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         Select_in = ~Select_in;
         #1;
         tests_run++;
         if (Y_comb_out !== exp_comb[i]) begin
            tests_failed++;
            $display("FAIL toggle_comb[%0d]: got %h, required %h", i, Y_comb_out, exp_comb[i]);
         end
         tests_run++;
         if (Y_out !== exp_prev) begin
            tests_failed++;
            $display("FAIL toggle_hold[%0d]: got %h, required %h", i, Y_out, exp_prev);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (Y_out !== exp_comb[i]) begin
            tests_failed++;
            $display("FAIL toggle_y[%0d]: got %h, required %h", i, Y_out, exp_comb[i]);
         end
         exp_prev = exp_comb[i];
      end
   endtask

   task automatic test_hold();
      // Y_out is 00 here; wiggle inputs between edges and confirm it holds.
      @(negedge clk);
      A_in = 8'hFF;
      B_in = 8'hAA;
      #2;
      A_in = 8'h00;
      B_in = 8'h01;
      #2;
      tests_run++;
      if (Y_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL hold_between_edges: got %h, required 00", Y_out);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      Select_in = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (Y_out !== 8'h01) begin
         tests_failed++;
         $display("FAIL areset_setup: got %h, required 01", Y_out);
      end
      #4;
      reset = 1'b0;
      #1;
      tests_run++;
      if (Y_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL areset_y_immediate: got %h, required 00", Y_out);
      end
      tests_run++;
      if (valid_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_valid_immediate: got %b, required 0", valid_out);
      end
      tests_run++;
      if (Y_comb_out !== 8'h01) begin
         tests_failed++;
         $display("FAIL areset_comb_unaffected: got %h, required 01", Y_comb_out);
      end
      // Held in reset across an edge: nothing is captured.
      @(posedge clk);
      #1;
      tests_run++;
      if (Y_out !== 8'h00 || valid_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL areset_held: got y=%h v=%b, required y=00 v=0", Y_out, valid_out);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (Y_out !== 8'h01 || valid_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL areset_first_capture: got y=%h v=%b, required y=01 v=1", Y_out, valid_out);
      end
   endtask

   // Wide vectors, changing every cycle: {A_in, B_in, Select_in, expected, parity}.
   task automatic test_wide();
      logic [W-1:0] va   [6] = '{8'hA5, 8'hA5, 8'h07, 8'h07, 8'hFF, 8'h80};
      logic [W-1:0] vb   [6] = '{8'h3C, 8'h3C, 8'hF0, 8'hF0, 8'h00, 8'h01};
      logic         vs   [6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
      logic [W-1:0] vexp [6] = '{8'h3C, 8'hA5, 8'h07, 8'hF0, 8'hFF, 8'h01};
      logic         vpar [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         A_in      = va[i];
         B_in      = vb[i];
         Select_in = vs[i];
         #1;
         tests_run++;
         if (Y_comb_out !== vexp[i]) begin
            tests_failed++;
            $display("FAIL wide_comb[%0d]: got %h, required %h", i, Y_comb_out, vexp[i]);
         end
         @(posedge clk);
         #1;
         tests_run++;
         if (Y_out !== vexp[i]) begin
            tests_failed++;
            $display("FAIL wide_y[%0d]: got %h, required %h", i, Y_out, vexp[i]);
         end
`ifdef MUX_2X1_REG_PARITY_EN
         tests_run++;
         if (Y_parity_out !== vpar[i]) begin
            tests_failed++;
            $display("FAIL wide_parity[%0d]: got %b, required %b", i, Y_parity_out, vpar[i]);
         end
`else
         if (vpar[i] === 1'bx) $display("[TB] note: parity table entry %0d undefined", i);
`endif
      end
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      test_reset();
      test_release();
      test_select();
      test_toggle();
      test_hold();
      test_async_reset();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
